// File: rtl/yacht_pkg.sv
// Shared definitions for the yacht dice datapath: die geometry, LFSR taps,
// dice-engine state encoding and the dice_vals packing macro.
package yacht_pkg;

    localparam int NUM_DICE  = 5;
    localparam int DIE_W     = 3;
    localparam int FACE_MIN  = 1;
    localparam int FACE_MAX  = 6;
    localparam int LFSR_W    = 16;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        DONE
    } engine_state_t;

endpackage

`ifndef YACHT_DIE
`define YACHT_DIE(vec, i) vec[yacht_pkg::DIE_W*(i) +: yacht_pkg::DIE_W]
`endif

// File: rtl/dice_lfsr.sv
// Free-running 16-bit Galois LFSR; an all-zero seed is replaced by 1 so the
// register can never lock up.
module dice_lfsr
    import yacht_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_en,
    output logic [15:0] state
);

    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED_NZ;
        end else if (step_en) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : '0);
        end
    end

endmodule

// File: rtl/dice_roll_engine.sv
// Dice roll engine: re-rolls un-held dice on request using LFSR rejection
// sampling, and owns the per-turn hold mask, hold cursor and roll counter.
module dice_roll_engine #(
    parameter int          NUM_DICE  = yacht_pkg::NUM_DICE,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_RETRY = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  roll_trigger,
    input  logic                  turn_start,
    input  logic                  hold_en,
    input  logic                  btn_hold_toggle,
    input  logic                  btn_cursor_next,
    output logic                  rolling,
    output logic                  roll_done,
    output logic [3*NUM_DICE-1:0] dice_vals,
    output logic [NUM_DICE-1:0]   hold_mask,
    output logic [2:0]            cursor,
    output logic [1:0]            roll_count
);

    import yacht_pkg::*;

    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    engine_state_t        state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [15:0]          lfsr;
    logic [12:0]          lfsr_unused;
    logic [2:0]           cand;
    logic                 die_wr;
    logic [2:0]           die_val;
    logic                 advance;
    logic [3*NUM_DICE-1:0] dice_q;
    logic [NUM_DICE-1:0]  hold_q;
    logic [2:0]           cursor_q;
    logic [1:0]           count_q;
    logic                 done_q;

    dice_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .step_en (1'b1),
        .state   (lfsr)
    );

    assign cand        = lfsr[2:0];
    assign lfsr_unused = lfsr[15:3];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        die_wr  = 1'b0;
        die_val = '0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (roll_trigger) begin
                    state_d = ROLL;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            ROLL: begin
                if (hold_q[idx_q]) begin
                    advance = 1'b1;
                end else if (cand < 3'(FACE_MAX)) begin
                    die_wr  = 1'b1;
                    die_val = cand + 3'(FACE_MIN);
                    retry_d = '0;
                    advance = 1'b1;
                end else if (retry_q == RW'(MAX_RETRY)) begin
                    die_wr  = 1'b1;
                    die_val = {1'b0, lfsr[1:0]} + 3'(FACE_MIN);
                    retry_d = '0;
                    advance = 1'b1;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
                if (advance) begin
                    if (idx_q == 3'(NUM_DICE - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // turn_start aborts from any state and suppresses the die write of that cycle
        if (turn_start) begin
            state_d = IDLE;
            die_wr  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            dice_q  <= {NUM_DICE{3'(FACE_MIN)}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            done_q  <= (state_q == DONE) && !turn_start;
            if (die_wr) begin
                `YACHT_DIE(dice_q, idx_q) <= die_val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q   <= '0;
            cursor_q <= '0;
            count_q  <= '0;
        end else if (turn_start) begin
            hold_q   <= '0;
            cursor_q <= '0;
            count_q  <= '0;
        end else begin
            // toggle uses the pre-advance cursor when both buttons fire together
            if (hold_en && btn_hold_toggle && state_q == IDLE && count_q != 2'd0) begin
                hold_q[cursor_q] <= ~hold_q[cursor_q];
            end
            if (hold_en && btn_cursor_next) begin
                cursor_q <= (cursor_q == 3'(NUM_DICE - 1)) ? 3'd0 : cursor_q + 3'd1;
            end
            if (state_q == DONE && count_q != 2'd3) begin
                count_q <= count_q + 2'd1;
            end
        end
    end

    assign rolling    = (state_q == ROLL);
    assign roll_done  = done_q;
    assign dice_vals  = dice_q;
    assign hold_mask  = hold_q;
    assign cursor     = cursor_q;
    assign roll_count = count_q;

endmodule

// File: tb/tb_dice_roll_engine.sv
// Self-checking bench for dice_roll_engine: table-driven hold/cursor/count
// vectors plus hand sequences for abort, fallback mapping and reset mid-roll.
module tb_dice_roll_engine;

    localparam int N = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        roll_trigger, turn_start, hold_en, btn_hold_toggle, btn_cursor_next;
    logic        rolling, roll_done;
    logic [14:0] dice_vals;
    logic [4:0]  hold_mask;
    logic [2:0]  cursor;
    logic [1:0]  roll_count;

    logic        trig_b;
    logic        rolling_b, roll_done_b;
    logic [14:0] dice_vals_b;
    logic [4:0]  hold_mask_b;
    logic [2:0]  cursor_b;
    logic [1:0]  roll_count_b;

    int checks   = 0;
    int failures = 0;

    logic [15:0] lfsr_m, lfsr_b;
    logic [14:0] exp_dice = 15'b001_001_001_001_001;
    logic [14:0] exp_dice_b = 15'b001_001_001_001_001;
    logic [4:0]  exp_hold = 5'b00000;

    dice_roll_engine #(.NUM_DICE(5), .SEED(16'hACE1), .MAX_RETRY(7)) dut (
        .clk             (clk),
        .reset           (reset),
        .roll_trigger    (roll_trigger),
        .turn_start      (turn_start),
        .hold_en         (hold_en),
        .btn_hold_toggle (btn_hold_toggle),
        .btn_cursor_next (btn_cursor_next),
        .rolling         (rolling),
        .roll_done       (roll_done),
        .dice_vals       (dice_vals),
        .hold_mask       (hold_mask),
        .cursor          (cursor),
        .roll_count      (roll_count)
    );

    // zero seed and MAX_RETRY = 0: every rejected candidate takes the fallback mapping
    dice_roll_engine #(.NUM_DICE(5), .SEED(16'h0000), .MAX_RETRY(0)) dut_b (
        .clk             (clk),
        .reset           (reset),
        .roll_trigger    (trig_b),
        .turn_start      (1'b0),
        .hold_en         (1'b0),
        .btn_hold_toggle (1'b0),
        .btn_cursor_next (1'b0),
        .rolling         (rolling_b),
        .roll_done       (roll_done_b),
        .dice_vals       (dice_vals_b),
        .hold_mask       (hold_mask_b),
        .cursor          (cursor_b),
        .roll_count      (roll_count_b)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_m <= 16'hACE1;
            lfsr_b <= 16'h0001;
        end else begin
            lfsr_m <= lstep(lfsr_m);
            lfsr_b <= lstep(lfsr_b);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Roll outcome from the LFSR value in the trigger cycle; limit caps decision cycles.
    task automatic predict(input logic [15:0] l0, input int max_retry, input logic [4:0] hold,
                           input int limit, inout logic [14:0] dv, output int cyc);
        logic [15:0] l;
        int i, retry;
        l = l0; i = 0; retry = 0; cyc = 0;
        while (i < N && cyc < limit) begin
            l = lstep(l);
            cyc++;
            if (hold[i]) begin
                i++;
            end else if (l[2:0] < 3'd6) begin
                dv[3*i +: 3] = l[2:0] + 3'd1;
                retry = 0;
                i++;
            end else if (retry == max_retry) begin
                dv[3*i +: 3] = {1'b0, l[1:0]} + 3'd1;
                retry = 0;
                i++;
            end else begin
                retry++;
            end
        end
    endtask

    task automatic do_roll(input bit extra);
        logic [15:0] l;
        logic [14:0] pd;
        int cyc, cnt;
        @(negedge clk);
        l = lfsr_m;
        roll_trigger = 1'b1;
        pd = exp_dice;
        predict(l, 7, exp_hold, 1000, pd, cyc);
        @(negedge clk);
        roll_trigger = 1'b0;
        cnt = 1;
        check("rolling_rise", rolling, 1);
        while (!roll_done && cnt < 300) begin
            roll_trigger = extra && (cnt == 2);
            @(negedge clk);
            cnt++;
        end
        roll_trigger = 1'b0;
        check("roll_latency", cnt, cyc + 2);
        check("roll_dice", dice_vals, pd);
        exp_dice = pd;
        @(negedge clk);
        check("roll_done_single", {rolling, roll_done}, 0);
    endtask

    task automatic pulse(input bit t, input bit n);
        @(negedge clk);
        hold_en = 1'b1; btn_hold_toggle = t; btn_cursor_next = n;
        @(negedge clk);
        hold_en = 1'b0; btn_hold_toggle = 1'b0; btn_cursor_next = 1'b0;
    endtask

    typedef struct {
        bit         roll_first;
        bit         extra;
        bit         ts;
        bit         en;
        bit         tog;
        bit         nxt;
        logic [4:0] hold;
        logic [2:0] cur;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [15:0] l;
        logic [14:0] pd;
        int cyc, cnt;
        bit seen;

        vecs[0]  = '{0, 0, 0, 1, 1, 0, 5'b00000, 3'd0, 2'd0};
        vecs[1]  = '{0, 0, 0, 0, 0, 1, 5'b00000, 3'd0, 2'd0};
        vecs[2]  = '{0, 0, 0, 1, 0, 1, 5'b00000, 3'd1, 2'd0};
        vecs[3]  = '{0, 0, 1, 0, 0, 0, 5'b00000, 3'd0, 2'd0};
        vecs[4]  = '{1, 0, 0, 1, 0, 1, 5'b00000, 3'd1, 2'd1};
        vecs[5]  = '{0, 0, 0, 1, 0, 1, 5'b00000, 3'd2, 2'd1};
        vecs[6]  = '{0, 0, 0, 1, 1, 0, 5'b00100, 3'd2, 2'd1};
        vecs[7]  = '{0, 0, 0, 0, 1, 0, 5'b00100, 3'd2, 2'd1};
        vecs[8]  = '{0, 0, 0, 1, 0, 1, 5'b00100, 3'd3, 2'd1};
        vecs[9]  = '{0, 0, 0, 1, 0, 1, 5'b00100, 3'd4, 2'd1};
        vecs[10] = '{0, 0, 0, 1, 1, 0, 5'b10100, 3'd4, 2'd1};
        vecs[11] = '{1, 0, 0, 0, 0, 0, 5'b10100, 3'd4, 2'd2};
        vecs[12] = '{1, 1, 0, 0, 0, 0, 5'b10100, 3'd4, 2'd3};
        vecs[13] = '{1, 0, 0, 0, 0, 0, 5'b10100, 3'd4, 2'd3};
        vecs[14] = '{0, 0, 0, 1, 0, 1, 5'b10100, 3'd0, 2'd3};
        vecs[15] = '{0, 0, 0, 1, 1, 0, 5'b10101, 3'd0, 2'd3};
        vecs[16] = '{0, 0, 1, 1, 1, 1, 5'b00000, 3'd0, 2'd0};

        reset = 1'b1;
        roll_trigger = 1'b0; turn_start = 1'b0; hold_en = 1'b0;
        btn_hold_toggle = 1'b0; btn_cursor_next = 1'b0; trig_b = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dice", dice_vals, 15'b001_001_001_001_001);
        check("rst_hold", hold_mask, 0);
        check("rst_cursor", cursor, 0);
        check("rst_count", roll_count, 0);
        check("rst_flags", {rolling, roll_done}, 0);
        check("rst_b_dice", dice_vals_b, 15'b001_001_001_001_001);
        reset = 1'b0;

        for (int k = 0; k < 17; k++) begin
            if (vecs[k].roll_first) do_roll(vecs[k].extra);
            @(negedge clk);
            turn_start = vecs[k].ts; hold_en = vecs[k].en;
            btn_hold_toggle = vecs[k].tog; btn_cursor_next = vecs[k].nxt;
            @(negedge clk);
            turn_start = 1'b0; hold_en = 1'b0; btn_hold_toggle = 1'b0; btn_cursor_next = 1'b0;
            exp_hold = vecs[k].hold;
            check($sformatf("vec%0d_hold", k), hold_mask, vecs[k].hold);
            check($sformatf("vec%0d_cursor", k), cursor, vecs[k].cur);
            check($sformatf("vec%0d_count", k), roll_count, vecs[k].cnt);
        end

        // turn_start in the third ROLL cycle: two dice decided, no roll_done
        do_roll(1'b0);
        @(negedge clk);
        l = lfsr_m;
        roll_trigger = 1'b1;
        @(negedge clk);
        roll_trigger = 1'b0;
        @(negedge clk);
        @(negedge clk);
        turn_start = 1'b1;
        pd = exp_dice;
        predict(l, 7, exp_hold, 2, pd, cyc);
        @(negedge clk);
        turn_start = 1'b0;
        check("abort_rolling", rolling, 0);
        check("abort_dice", dice_vals, pd);
        check("abort_count", roll_count, 0);
        exp_dice = pd;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (roll_done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);

        // cursor at last die: toggle and next together
        do_roll(1'b0);
        repeat (4) pulse(1'b0, 1'b1);
        check("t6_cursor4", cursor, 4);
        pulse(1'b1, 1'b1);
        check("t6_hold", hold_mask, 5'b10000);
        check("t6_cursor_wrap", cursor, 0);

        // fallback-mapping instance: never rejects, fixed latency
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            l = lfsr_b;
            trig_b = 1'b1;
            pd = exp_dice_b;
            predict(l, 0, 5'b00000, 1000, pd, cyc);
            @(negedge clk);
            trig_b = 1'b0;
            cnt = 1;
            while (!roll_done_b && cnt < 300) begin
                @(negedge clk);
                cnt++;
            end
            check($sformatf("b_latency%0d", r), cnt, N + 2);
            check($sformatf("b_dice%0d", r), dice_vals_b, pd);
            exp_dice_b = pd;
            @(negedge clk);
        end

        // asynchronous reset mid-roll
        @(negedge clk);
        roll_trigger = 1'b1;
        @(negedge clk);
        roll_trigger = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_dice", dice_vals, 15'b001_001_001_001_001);
        check("arst_rolling", rolling, 0);
        check("arst_hold", hold_mask, 0);
        check("arst_count", roll_count, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
